// File: rtl/palette_selector.sv
// Colour palette selector: debounced left/right stepping through swatches plus a menu-bar overlay.
// Optional build macro PALETTE_AUTOREPEAT_EN makes a held button repeat once per lockout period.
`timescale 1ns/1ps
module palette_selector #(
  parameter int          NUM_COLOURS     = 13,
  parameter int          DEBOUNCE_CYCLES = 25000000,
  parameter int          WRAP            = 0,
  parameter int          MENU_Y0         = 54,
  parameter logic [15:0] HIGHLIGHT       = 16'hF800
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [12:0] pixel_index,
  input  logic        sel_en,
  input  logic        menu_en,
  input  logic        btnR,
  input  logic        btnL,
  input  logic [15:0] curr_pixel_oled,
  output logic [15:0] oled_data,
  output logic [15:0] selected_colour,
  output logic [3:0]  sel_idx,
  output logic        sel_changed
);

  localparam int          LW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  LAST = 4'(NUM_COLOURS - 1);
  localparam logic [6:0]  Y0   = 7'(MENU_Y0);
  localparam logic [6:0]  Y9   = 7'(MENU_Y0 + 9);
  localparam logic [6:0]  YB0  = 7'(MENU_Y0 + 2);
  localparam logic [6:0]  YB1  = 7'(MENU_Y0 + 7);
  localparam logic [6:0]  YF0  = 7'(MENU_Y0 + 4);
  localparam logic [6:0]  YF1  = 7'(MENU_Y0 + 5);

  function automatic logic [15:0] palette(input logic [3:0] k);
    case (k)
      4'd0:    palette = 16'h0000;
      4'd1:    palette = 16'hFED3;
      4'd2:    palette = 16'hFD46;
      4'd3:    palette = 16'hC240;
      4'd4:    palette = 16'hF800;
      4'd5:    palette = 16'hCB5D;
      4'd6:    palette = 16'h1619;
      4'd7:    palette = 16'h2B58;
      4'd8:    palette = 16'h0C8A;
      4'd9:    palette = 16'h7687;
      4'd10:   palette = 16'hFFCB;
      4'd11:   palette = 16'h7BEF;
      4'd12:   palette = 16'hC618;
      default: palette = 16'h0000;
    endcase
  endfunction

  assign selected_colour = palette(sel_idx);

  logic [1:0]    sync_r;
  logic [1:0]    sync_l;
  logic [LW-1:0] lockout;
  logic          arm;
  logic          one_btn;
  logic          at_end;
  logic          do_step;
  logic [3:0]    next_idx;

  assign one_btn = sync_r[1] ^ sync_l[1];
  assign at_end  = sync_r[1] ? (sel_idx == LAST) : (sel_idx == 4'd0);
  assign do_step = sel_en && (lockout == '0) && arm && one_btn && ((WRAP != 0) || !at_end);

  always_comb begin
    next_idx = sel_idx;
    if (sync_r[1])
      next_idx = at_end ? 4'd0 : sel_idx + 4'd1;
    else
      next_idx = at_end ? LAST : sel_idx - 4'd1;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_r      <= '0;
      sync_l      <= '0;
      lockout     <= '0;
      sel_idx     <= '0;
      sel_changed <= 1'b0;
    end else begin
      sync_r      <= {sync_r[0], btnR};
      sync_l      <= {sync_l[0], btnL};
      sel_changed <= do_step;
      if (do_step) begin
        sel_idx <= next_idx;
        lockout <= LOCK_LOAD;
      end else if (lockout != '0) begin
        lockout <= lockout - LW'(1);
      end
    end
  end

`ifdef PALETTE_AUTOREPEAT_EN
  assign arm = 1'b1;
`else
  // Re-arm only once both buttons are seen released, so a held button steps once.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      arm <= 1'b1;
    else if (do_step)
      arm <= 1'b0;
    else if (!sync_r[1] && !sync_l[1])
      arm <= 1'b1;
  end
`endif

  logic [6:0]  px;
  logic [6:0]  py;
  logic [6:0]  bx0;
  logic [6:0]  bx1;
  logic        border;
  logic        box_sel;
  logic        fill_hit;
  logic [15:0] fill_col;

  assign px  = 7'(pixel_index % 13'd96);
  assign py  = 7'(pixel_index / 13'd96);
  assign bx0 = 7'd3 + 7'd7 * {3'b000, sel_idx};
  assign bx1 = bx0 + 7'd5;

  assign border  = (py == Y0) || (py == Y9) ||
                   (((px == 7'd0) || (px == 7'd95)) && (py > Y0) && (py < Y9));
  assign box_sel = (py >= YB0) && (py <= YB1) && (px >= bx0) && (px <= bx1) &&
                   ((px == bx0) || (px == bx1) || (py == YB0) || (py == YB1));

  always_comb begin
    fill_hit = 1'b0;
    fill_col = 16'h0000;
    if ((py == YF0) || (py == YF1)) begin
      for (int k = 0; k < NUM_COLOURS; k++) begin
        if ((px >= 7'(5 + 7 * k)) && (px <= 7'(6 + 7 * k))) begin
          fill_hit = 1'b1;
          fill_col = palette(4'(k));
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      oled_data <= 16'h0000;
    else if (sel_en && menu_en) begin
      if (border)
        oled_data <= 16'h0000;
      else if (box_sel)
        oled_data <= HIGHLIGHT;
      else if (fill_hit)
        oled_data <= fill_col;
      else
        oled_data <= curr_pixel_oled;
    end else
      oled_data <= curr_pixel_oled;
  end

endmodule
